// File: rtl/snn_infer_sched_pkg.sv
// Shared constants and FSM encoding for the frame-level SNN inference scheduler.
package snn_infer_sched_pkg;
  localparam int NUM_OUTPUTS     = 10;
  localparam int PIXEL_BITS      = 8;
  localparam int TS_W            = 8;
  localparam int SPIKE_CNT_W     = 8;
  localparam int SCHED_DRAIN_CYC = 40;
  localparam int SHIFT_W         = $clog2(PIXEL_BITS);
  localparam int ID_W            = 4;
  localparam int QUIET_W         = $clog2(SCHED_DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_REQ, S_DRAIN, S_ARGMAX, S_DONE
  } sched_state_e;
endpackage

// File: rtl/snn_infer_sched_if.sv
// Scheduler bus: host control/results, CIM handshake and output-FIFO snoop.
interface snn_infer_sched_if;
  import snn_infer_sched_pkg::*;
  logic                   i_start;
  logic                   i_abort;
  logic [TS_W-1:0]        i_timesteps;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_soft_reset_pulse;
  logic                   o_cim_req;
  logic                   i_cim_ack;
  logic [SHIFT_W-1:0]     o_bitplane_shift;
  logic                   i_spike_push;
  logic [ID_W-1:0]        i_spike_id;
  logic [ID_W-1:0]        o_pred_class;
  logic [SPIKE_CNT_W-1:0] o_pred_count;
  logic                   o_pred_valid;

  modport master (
    input  i_start, i_abort, i_timesteps, i_cim_ack, i_spike_push, i_spike_id,
    output o_busy, o_done, o_soft_reset_pulse, o_cim_req, o_bitplane_shift,
           o_pred_class, o_pred_count, o_pred_valid
  );
  modport slave (
    output i_start, i_abort, i_timesteps, i_cim_ack, i_spike_push, i_spike_id,
    input  o_busy, o_done, o_soft_reset_pulse, o_cim_req, o_bitplane_shift,
           o_pred_class, o_pred_count, o_pred_valid
  );
endinterface

// File: rtl/snn_infer_sched_spike_counter_bank.sv
// Per-neuron saturating spike counters with synchronous clear and indexed read.
module snn_infer_sched_spike_counter_bank
  import snn_infer_sched_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic                   i_inc,
  input  logic [ID_W-1:0]        i_inc_id,
  input  logic [ID_W-1:0]        i_rd_idx,
  output logic [SPIKE_CNT_W-1:0] o_rd_cnt
);
  logic [NUM_OUTPUTS-1:0][SPIKE_CNT_W-1:0] r_cnt;

  // Ids at or above NUM_OUTPUTS match no counter and are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_OUTPUTS; i++)
        if (i_inc && i_inc_id == ID_W'(i) && r_cnt[i] != '1)
          r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  always_comb begin
    o_rd_cnt = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++)
      if (i_rd_idx == ID_W'(i)) o_rd_cnt = r_cnt[i];
  end
endmodule

// File: rtl/snn_infer_sched.sv
// Inference scheduler: clear, T x bit-plane CIM stepping, drain, argmax.
module snn_infer_sched
  import snn_infer_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  snn_infer_sched_if.master bus
);
  sched_state_e           r_state, w_next;
  logic [TS_W-1:0]        r_ts, r_ts_idx;
  logic [SHIFT_W-1:0]     r_shift;
  logic [QUIET_W-1:0]     r_quiet;
  logic [ID_W-1:0]        r_scan, r_best_idx, r_pred_class;
  logic [SPIKE_CNT_W-1:0] r_best_cnt, r_pred_count, w_rd_cnt;
  logic                   r_pred_valid;
  logic w_start_acc, w_abort, w_ack, w_last_plane, w_last_ts;
  logic w_scan_last, w_better, w_quiet_done, w_count_en;

  assign w_start_acc  = (r_state == S_IDLE) && bus.i_start;
  assign w_abort      = (r_state != S_IDLE) && bus.i_abort;
  // An ack colliding with abort is discarded.
  assign w_ack        = (r_state == S_REQ) && bus.i_cim_ack && !bus.i_abort;
  assign w_last_plane = (r_shift == '0);
  assign w_last_ts    = ({1'b0, r_ts_idx} + 1'b1) == {1'b0, r_ts};
  assign w_scan_last  = (r_scan == ID_W'(NUM_OUTPUTS - 1));
  assign w_better     = (w_rd_cnt > r_best_cnt);
  assign w_quiet_done = !bus.i_spike_push && (r_quiet == QUIET_W'(SCHED_DRAIN_CYC - 1));
  assign w_count_en   = (r_state == S_CLEAR) || (r_state == S_REQ) || (r_state == S_DRAIN);

  always_comb begin
    w_next                 = r_state;
    bus.o_busy             = (r_state != S_IDLE);
    bus.o_done             = (r_state == S_DONE);
    bus.o_soft_reset_pulse = (r_state == S_CLEAR);
    bus.o_cim_req          = (r_state == S_REQ);
    case (r_state)
      S_IDLE:   if (bus.i_start) w_next = S_CLEAR;
      S_CLEAR:  w_next = (r_ts == '0) ? S_DRAIN : S_REQ;
      S_REQ:    if (w_ack && w_last_plane && w_last_ts) w_next = S_DRAIN;
      S_DRAIN:  if (w_quiet_done) w_next = S_ARGMAX;
      S_ARGMAX: if (w_scan_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ts         <= '0;
      r_ts_idx     <= '0;
      r_shift      <= SHIFT_W'(PIXEL_BITS - 1);
      r_quiet      <= '0;
      r_scan       <= '0;
      r_best_idx   <= '0;
      r_best_cnt   <= '0;
      r_pred_class <= '0;
      r_pred_count <= '0;
      r_pred_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_ts         <= bus.i_timesteps;
        r_ts_idx     <= '0;
        r_shift      <= SHIFT_W'(PIXEL_BITS - 1);
        r_pred_valid <= 1'b0;
      end
      if (w_ack) begin
        if (!w_last_plane) begin
          r_shift <= r_shift - 1'b1;
        end else if (!w_last_ts) begin
          r_ts_idx <= r_ts_idx + 1'b1;
          r_shift  <= SHIFT_W'(PIXEL_BITS - 1);
        end
      end
      r_quiet <= (r_state == S_DRAIN && !bus.i_spike_push) ? r_quiet + 1'b1 : '0;
      // Strictly-greater replace keeps ties on the lowest index.
      if (r_state == S_ARGMAX && !w_abort) begin
        r_scan <= r_scan + 1'b1;
        if (w_better) begin
          r_best_idx <= r_scan;
          r_best_cnt <= w_rd_cnt;
        end
        if (w_scan_last) begin
          r_pred_class <= w_better ? r_scan : r_best_idx;
          r_pred_count <= w_better ? w_rd_cnt : r_best_cnt;
          r_pred_valid <= 1'b1;
        end
      end else begin
        r_scan     <= '0;
        r_best_idx <= '0;
        r_best_cnt <= '0;
      end
    end
  end

  snn_infer_sched_spike_counter_bank u_cnt (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clr    (w_start_acc),
    .i_inc    (w_count_en && bus.i_spike_push),
    .i_inc_id (bus.i_spike_id),
    .i_rd_idx (r_scan),
    .o_rd_cnt (w_rd_cnt)
  );

  assign bus.o_bitplane_shift = r_shift;
  assign bus.o_pred_class     = r_pred_class;
  assign bus.o_pred_count     = r_pred_count;
  assign bus.o_pred_valid     = r_pred_valid;
endmodule

// File: doc/snn_infer_sched.md
Name: snn_infer_sched

Overview:
- Frame-level inference scheduler for the LIF output stage.
- Per inference it:
  - issues one soft_reset_pulse to clear membranes and the spike queue;
  - steps the CIM/ADC path through T timesteps × PIXEL_BITS bit-planes (MSB→LSB) via a req/ack handshake, driving bitplane_shift;
  - snoops output-FIFO pushes to count spikes per neuron;
  - drains, then computes the argmax class in hardware.
- Sits between reg_bank (start/timesteps/results) and cim_array_ctrl + lif_neurons.

Parameters:
- NUM_OUTPUTS, 10, number of output neurons / spike counters.
- PIXEL_BITS, 8, bit-planes per timestep; bitplane_shift runs PIXEL_BITS-1 down to 0.
- TS_W, 8, width of the timestep count.
- CNT_W, 8, width of each per-neuron spike counter (saturating).
- DRAIN_CYC, 40, quiet cycles with no spike push before results are taken.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  1-cycle pulse; begins an inference when idle.
- abort  in  1  1-cycle pulse; cancels an inference in flight.
- timesteps  in  TS_W  number of timesteps T; sampled on the accepted start.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  1-cycle pulse when results are valid.
- soft_reset_pulse  out  1  1-cycle pulse to lif_neurons.
- cim_req  out  1  request one bit-plane MAC+ADC; level signal held until ack.
- cim_ack  in  1  1-cycle pulse from cim_array_ctrl; neuron_in_valid is issued in the same cycle.
- bitplane_shift  out  $clog2(PIXEL_BITS)  current bit-plane weight.
- spike_push  in  1  tap of out_fifo_push.
- spike_id  in  4  tap of out_fifo_wdata.
- pred_class  out  4  argmax neuron index.
- pred_count  out  CNT_W  spike count of pred_class.
- pred_valid  out  1  sticky; set by done, cleared by the next accepted start.

Behaviour:
Reset values:
- FSM = IDLE; all counters cleared.
- busy, done, soft_reset_pulse, cim_req, pred_valid = 0.
- bitplane_shift = PIXEL_BITS-1; pred_class = 0; pred_count = 0.

FSM states: IDLE, CLEAR, REQ, DRAIN, ARGMAX, DONE.
- IDLE:
  - On start: latch T, clear spike counters, pred_valid=0 → CLEAR.
  - start while busy is ignored.
- CLEAR (1 cycle):
  - soft_reset_pulse=1; ts_idx=0; bitplane_shift=PIXEL_BITS-1.
  - Next state is REQ, or DRAIN if T==0 (no CIM requests issued).
- REQ:
  - cim_req=1; bitplane_shift is stable while cim_req is high.
  - On cim_ack with bitplane_shift>0: decrement the shift; stay in REQ with cim_req still high (back-to-back requests, no idle cycle).
  - On cim_ack with shift==0 and ts_idx<T-1: ts_idx++; shift reloads to PIXEL_BITS-1; stay in REQ.
  - On cim_ack with shift==0 and ts_idx==T-1: cim_req=0 next cycle → DRAIN.
  - cim_ack outside REQ is ignored.
- DRAIN:
  - quiet counter counts up each cycle; it resets to 0 on any spike_push.
  - Reaching DRAIN_CYC → ARGMAX. This covers lif's 32-deep queue under output-FIFO backpressure.
- ARGMAX:
  - Scans one neuron per cycle, index 0..NUM_OUTPUTS-1, for NUM_OUTPUTS cycles.
  - Replace the running best only on strictly greater count, so ties go to the lowest index.
  - Then → DONE.
- DONE (1 cycle):
  - done=1; pred_valid=1; pred_class and pred_count registered; → IDLE.

Spike counting:
- Counting is active in CLEAR, REQ and DRAIN.
- On spike_push with spike_id<NUM_OUTPUTS: cnt[spike_id]++, saturating at 2^CNT_W-1.
- spike_id≥NUM_OUTPUTS is ignored.

abort:
- Honoured in any non-IDLE state: → IDLE next cycle.
- cim_req and busy drop next cycle; no done pulse; pred_valid stays 0.
- A cim_ack arriving in the same cycle as abort is discarded.

Other boundary conditions:
- start and abort in the same cycle while IDLE: start wins; abort is ignored because it only acts when busy.
- rst mid-operation: all outputs return to their reset values immediately (asynchronous).

Latency:
- Minimum start→done = 1 (CLEAR) + T·PIXEL_BITS acks + DRAIN_CYC + NUM_OUTPUTS + 1.

Decomposition:
- Add to snn_soc_pkg:
  - sched_state_e enum;
  - SPIKE_CNT_W and SCHED_DRAIN_CYC constants (reusing NUM_OUTPUTS and PIXEL_BITS).
- One natural sub-module: spike_counter_bank, holding NUM_OUTPUTS saturating counters with clear/inc/read-index ports. The FSM, handshake and argmax stay in the top module.

Test Plan:
- T=1, ack 2 cycles after each req, no spikes:
  - exactly 8 acks consumed; bitplane_shift sequence 7,6,…,0;
  - one soft_reset_pulse;
  - done after DRAIN_CYC+NUM_OUTPUTS+1 cycles past the last ack;
  - pred_class=0, pred_count=0.
- T=3, spikes injected: id3 ×5, id7 ×5, id1 ×2:
  - 24 acks consumed;
  - pred_class=3 (tie goes to lowest index), pred_count=5, pred_valid=1.
- Spike pushes continue every 10 cycles for 200 cycles after the last ack:
  - done is not raised until 40 quiet cycles after the final push.
- 300 pushes of id9:
  - pred_count saturates at 255; pred_class=9.
  - spike_id=12 pushes leave all counts unchanged.
- abort during REQ at bit-plane 4 of timestep 2:
  - busy and cim_req low next cycle; no done; pred_valid=0;
  - a new start reissues soft_reset_pulse and shift restarts at 7.
- T=0: no cim_req asserted; done arrives after CLEAR+DRAIN+ARGMAX.
- start while busy: ignored; T is not relatched.
- rst asserted mid-DRAIN: all outputs return to reset values in the same cycle.
